// File: rtl/mc_pkg.sv
// mc_pkg: shared types and encodings for the multi-cycle MIPS control unit.
//   state_e  - controller sequencing states
//   iclass_e - decoded instruction class
//   OP_*/FN_* opcode and R-type funct values; ALUOP_*, PCSRC_*, BSEL_*,
//   RDST_*, WDSEL_* datapath select encodings.
package mc_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_e;

    typedef enum logic [3:0] {
        CL_RALU = 4'd0,
        CL_ORI  = 4'd1,
        CL_LUI  = 4'd2,
        CL_LW   = 4'd3,
        CL_SW   = 4'd4,
        CL_BEQ  = 4'd5,
        CL_J    = 4'd6,
        CL_JAL  = 4'd7,
        CL_JR   = 4'd8,
        CL_ILL  = 4'd9
    } iclass_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLL   = 6'b000000;
    localparam logic [5:0] FN_SLLV  = 6'b000100;
    localparam logic [5:0] FN_JR    = 6'b001000;

    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_LUI  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_AND  = 4'd4;
    localparam logic [3:0] ALUOP_SLL  = 4'd5;
    localparam logic [3:0] ALUOP_SLLV = 4'd6;
    localparam logic [3:0] ALUOP_SLT  = 4'd7;

    localparam logic [1:0] PCSRC_INC  = 2'd0;
    localparam logic [1:0] PCSRC_BR   = 2'd1;
    localparam logic [1:0] PCSRC_JMP  = 2'd2;
    localparam logic [1:0] PCSRC_RS   = 2'd3;

    localparam logic [1:0] BSEL_RT    = 2'd0;
    localparam logic [1:0] BSEL_ZEXT  = 2'd1;
    localparam logic [1:0] BSEL_SEXT  = 2'd2;

    localparam logic [1:0] RDST_RT    = 2'd0;
    localparam logic [1:0] RDST_RD    = 2'd1;
    localparam logic [1:0] RDST_RA    = 2'd2;

    localparam logic [1:0] WDSEL_ALU  = 2'd0;
    localparam logic [1:0] WDSEL_MEM  = 2'd1;
    localparam logic [1:0] WDSEL_PC4  = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// mc_decode: combinational instruction decoder.
//   opcode_i    - instr[31:26]
//   funct_i     - instr[5:0]
//   iclass_o    - instruction class
//   alu_op_o    - ALU operation used while the instruction owns the ALU
//   alu_b_sel_o - ALU B operand select for the same
//   illegal_o   - opcode/funct combination not supported
import mc_pkg::*;

module mc_decode (
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output iclass_e    iclass_o,
    output logic [3:0] alu_op_o,
    output logic [1:0] alu_b_sel_o,
    output logic       illegal_o
);

    always_comb begin
        iclass_o    = CL_ILL;
        alu_op_o    = ALUOP_ADD;
        alu_b_sel_o = BSEL_RT;
        case (opcode_i)
            OP_RTYPE: begin
                iclass_o = CL_RALU;
                case (funct_i)
                    FN_ADDU: alu_op_o = ALUOP_ADD;
                    FN_SUBU: alu_op_o = ALUOP_SUB;
                    FN_AND:  alu_op_o = ALUOP_AND;
                    FN_OR:   alu_op_o = ALUOP_OR;
                    FN_SLT:  alu_op_o = ALUOP_SLT;
                    FN_SLL:  alu_op_o = ALUOP_SLL;
                    FN_SLLV: alu_op_o = ALUOP_SLLV;
                    FN_JR:   iclass_o = CL_JR;
                    default: iclass_o = CL_ILL;
                endcase
            end
            OP_ORI: begin
                iclass_o    = CL_ORI;
                alu_op_o    = ALUOP_OR;
                alu_b_sel_o = BSEL_ZEXT;
            end
            OP_LUI: begin
                iclass_o    = CL_LUI;
                alu_op_o    = ALUOP_LUI;
                alu_b_sel_o = BSEL_ZEXT;
            end
            OP_LW: begin
                iclass_o    = CL_LW;
                alu_b_sel_o = BSEL_SEXT;
            end
            OP_SW: begin
                iclass_o    = CL_SW;
                alu_b_sel_o = BSEL_SEXT;
            end
            OP_BEQ: begin
                iclass_o = CL_BEQ;
                alu_op_o = ALUOP_SUB;
            end
            OP_J:    iclass_o = CL_J;
            OP_JAL:  iclass_o = CL_JAL;
            default: iclass_o = CL_ILL;
        endcase
        illegal_o = (iclass_o == CL_ILL);
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit (FETCH/DECODE/EXEC/MEM/WB/HALT).
//   clk, reset         - clock; asynchronous active-low reset
//   instr              - instruction register contents
//   equal              - ALU A==B flag (beq)
//   mem_ready          - memory completes the outstanding request
//   ir_we, pc_we       - IR / PC load strobes; pc_src selects PC source
//   alu_op, alu_b_sel  - ALU operation and B operand select
//   reg_we, reg_dst, wd_sel - register file write strobe / dest / data select
//   mem_req, mem_we, mem_is_data - memory request, store, data-vs-fetch
//   illegal            - sticky unsupported-instruction flag
//   dbg_state          - current state
//
// state  | meaning
// FETCH  | request instruction at PC, load IR and PC+4 on mem_ready
// DECODE | classify IR; unsupported instruction -> HALT
// EXEC   | ALU op / branch / jump; jal links here
// MEM    | data access at ALU address, ALU controls held for a stable address
// WB     | register write from ALU or memory data
// HALT   | absorbing after an illegal instruction; left only by reset
import mc_pkg::*;

module mc_ctrl #(
    parameter int STATE_W = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        instr,
    input  logic               equal,
    input  logic               mem_ready,
    output logic               ir_we,
    output logic               pc_we,
    output logic [1:0]         pc_src,
    output logic [3:0]         alu_op,
    output logic [1:0]         alu_b_sel,
    output logic               reg_we,
    output logic [1:0]         reg_dst,
    output logic [1:0]         wd_sel,
    output logic               mem_req,
    output logic               mem_we,
    output logic               mem_is_data,
    output logic               illegal,
    output logic [STATE_W-1:0] dbg_state
);

    state_e     state_q, state_d;
    logic       illegal_q, illegal_d;

    iclass_e    iclass;
    logic [3:0] dec_alu_op;
    logic [1:0] dec_bsel;
    logic       dec_illegal;

    // Only opcode and funct take part in control decisions.
    logic       unused_instr;
    assign unused_instr = ^instr[25:6];

    mc_decode u_decode (
        .opcode_i    (instr[31:26]),
        .funct_i     (instr[5:0]),
        .iclass_o    (iclass),
        .alu_op_o    (dec_alu_op),
        .alu_b_sel_o (dec_bsel),
        .illegal_o   (dec_illegal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        illegal_d   = illegal_q;
        ir_we       = 1'b0;
        pc_we       = 1'b0;
        pc_src      = PCSRC_INC;
        alu_op      = ALUOP_ADD;
        alu_b_sel   = BSEL_RT;
        reg_we      = 1'b0;
        reg_dst     = RDST_RT;
        wd_sel      = WDSEL_ALU;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_is_data = 1'b0;
        // Outputs are gated by reset so a request in flight is dropped
        // the moment reset asserts, not at the next clock.
        if (reset) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_we   = 1'b1;
                        pc_we   = 1'b1;
                        pc_src  = PCSRC_INC;
                        state_d = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (dec_illegal) begin
                        illegal_d = 1'b1;
                        state_d   = ST_HALT;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    alu_op    = dec_alu_op;
                    alu_b_sel = dec_bsel;
                    case (iclass)
                        CL_RALU, CL_ORI, CL_LUI: state_d = ST_WB;
                        CL_LW, CL_SW:            state_d = ST_MEM;
                        CL_BEQ: begin
                            pc_src  = PCSRC_BR;
                            pc_we   = equal;
                            state_d = ST_FETCH;
                        end
                        CL_J: begin
                            pc_we   = 1'b1;
                            pc_src  = PCSRC_JMP;
                            state_d = ST_FETCH;
                        end
                        CL_JAL: begin
                            // PC already holds PC+4 from FETCH, so it is the link value.
                            pc_we   = 1'b1;
                            pc_src  = PCSRC_JMP;
                            reg_we  = 1'b1;
                            reg_dst = RDST_RA;
                            wd_sel  = WDSEL_PC4;
                            state_d = ST_FETCH;
                        end
                        CL_JR: begin
                            pc_we   = 1'b1;
                            pc_src  = PCSRC_RS;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_FETCH;
                    endcase
                end
                ST_MEM: begin
                    alu_op      = dec_alu_op;
                    alu_b_sel   = dec_bsel;
                    mem_req     = 1'b1;
                    mem_is_data = 1'b1;
                    mem_we      = (iclass == CL_SW);
                    if (mem_ready) begin
                        state_d = (iclass == CL_SW) ? ST_FETCH : ST_WB;
                    end
                end
                ST_WB: begin
                    alu_op    = dec_alu_op;
                    alu_b_sel = dec_bsel;
                    reg_we    = 1'b1;
                    reg_dst   = (iclass == CL_RALU) ? RDST_RD : RDST_RT;
                    wd_sel    = (iclass == CL_LW) ? WDSEL_MEM : WDSEL_ALU;
                    state_d   = ST_FETCH;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign illegal   = illegal_q;
    assign dbg_state = reset ? STATE_W'(state_q) : '0;

endmodule

// File: tb/tb_mc_ctrl.sv
// tb_mc_ctrl: directed + randomized check of mc_ctrl against a per-instruction
// cycle model built from the instruction set rules.
import mc_pkg::*;

module tb_mc_ctrl;

    typedef struct packed {
        logic       ir_we;
        logic       pc_we;
        logic [1:0] pc_src;
        logic [3:0] alu_op;
        logic [1:0] alu_b_sel;
        logic       reg_we;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       mem_req;
        logic       mem_we;
        logic       mem_is_data;
        logic       illegal;
        logic [2:0] dbg;
    } exp_t;

    localparam int K_R = 0, K_ORI = 1, K_LUI = 2, K_LW = 3, K_SW = 4,
                   K_BEQ = 5, K_J = 6, K_JAL = 7, K_JR = 8, K_ILL = 9;

    logic        clk, reset, equal, mem_ready;
    logic [31:0] instr;
    logic        ir_we, pc_we, reg_we, mem_req, mem_we, mem_is_data, illegal;
    logic [1:0]  pc_src, alu_b_sel, reg_dst, wd_sel;
    logic [3:0]  alu_op;
    logic [2:0]  dbg_state;

    int tests = 0;
    int fails = 0;

    logic [5:0] rfn [7] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h2a, 6'h00, 6'h04};
    int         rop [7] = '{0, 1, 4, 3, 7, 5, 6};
    logic [5:0] iops[7] = '{6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03};

    mc_ctrl #(.STATE_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .equal       (equal),
        .mem_ready   (mem_ready),
        .ir_we       (ir_we),
        .pc_we       (pc_we),
        .pc_src      (pc_src),
        .alu_op      (alu_op),
        .alu_b_sel   (alu_b_sel),
        .reg_we      (reg_we),
        .reg_dst     (reg_dst),
        .wd_sel      (wd_sel),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_is_data (mem_is_data),
        .illegal     (illegal),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void ref_decode(input logic [31:0] ins, output int kind,
                                       output logic [3:0] aop, output logic [1:0] bs);
        kind = K_ILL;
        aop  = 4'd0;
        bs   = 2'd0;
        if (ins[31:26] == 6'h00) begin
            if (ins[5:0] == 6'h08) kind = K_JR;
            else begin
                for (int i = 0; i < 7; i++) begin
                    if (ins[5:0] == rfn[i]) begin
                        kind = K_R;
                        aop  = 4'(rop[i]);
                    end
                end
            end
        end else begin
            case (ins[31:26])
                6'h0d: begin kind = K_ORI; aop = 4'd3; bs = 2'd1; end
                6'h0f: begin kind = K_LUI; aop = 4'd2; bs = 2'd1; end
                6'h23: begin kind = K_LW;  aop = 4'd0; bs = 2'd2; end
                6'h2b: begin kind = K_SW;  aop = 4'd0; bs = 2'd2; end
                6'h04: begin kind = K_BEQ; aop = 4'd1; bs = 2'd0; end
                6'h02: kind = K_J;
                6'h03: kind = K_JAL;
                default: kind = K_ILL;
            endcase
        end
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          idx;
        r = $urandom;
        if ($urandom_range(0, 8) <= 2) begin
            r[31:26] = 6'h00;
            idx = $urandom_range(0, 7);
            r[5:0] = (idx == 7) ? 6'h08 : rfn[idx];
        end else begin
            r[31:26] = iops[$urandom_range(0, 6)];
        end
        return r;
    endfunction

    // One clock: drive inputs after the falling edge, sample 1 time unit later.
    task automatic cyc(input logic rst, input logic mr, input logic eq,
                       input logic [31:0] ins, input exp_t e, input string tag);
        exp_t o;
        @(negedge clk);
        reset     = rst;
        mem_ready = mr;
        equal     = eq;
        instr     = ins;
        #1;
        o = {ir_we, pc_we, pc_src, alu_op, alu_b_sel, reg_we, reg_dst, wd_sel,
             mem_req, mem_we, mem_is_data, illegal, dbg_state};
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s instr=%h observed=%h expected=%h", tag, ins, o, e);
        end
    endtask

    // Full life of one instruction; eqx 0/1 forces equal in EXEC, 2 randomizes it.
    task automatic run_instr(input logic [31:0] ins, input int lf, input int ld, input int eqx);
        int         kind;
        logic [3:0] aop;
        logic [1:0] bs;
        logic       eq;
        exp_t       e;
        ref_decode(ins, kind, aop, bs);
        for (int i = 0; i < lf; i++) begin
            e = '0; e.mem_req = 1'b1; e.dbg = ST_FETCH;
            cyc(1'b1, 1'b0, rb(), ins, e, "fetch_wait");
        end
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.dbg = ST_FETCH;
        cyc(1'b1, 1'b1, rb(), ins, e, "fetch_done");
        e = '0; e.dbg = ST_DECODE;
        cyc(1'b1, rb(), rb(), ins, e, "decode");
        if (kind != K_ILL) begin
            eq = (eqx == 2) ? rb() : eqx[0];
            e = '0; e.dbg = ST_EXEC;
            case (kind)
                K_BEQ: begin e.alu_op = aop; e.pc_src = 2'd1; e.pc_we = eq; end
                K_J:   begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
                K_JAL: begin
                    e.pc_we = 1'b1; e.pc_src = 2'd2;
                    e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_sel = 2'd2;
                end
                K_JR:  begin e.pc_we = 1'b1; e.pc_src = 2'd3; end
                default: begin e.alu_op = aop; e.alu_b_sel = bs; end
            endcase
            cyc(1'b1, rb(), eq, ins, e, "exec");
            if (kind == K_LW || kind == K_SW) begin
                for (int i = 0; i <= ld; i++) begin
                    e = '0; e.dbg = ST_MEM;
                    e.mem_req = 1'b1; e.mem_is_data = 1'b1; e.mem_we = (kind == K_SW);
                    e.alu_op = aop; e.alu_b_sel = bs;
                    cyc(1'b1, (i == ld), rb(), ins, e, (i == ld) ? "mem_done" : "mem_wait");
                end
            end
            if (kind == K_R || kind == K_ORI || kind == K_LUI || kind == K_LW) begin
                e = '0; e.dbg = ST_WB; e.reg_we = 1'b1;
                e.reg_dst = (kind == K_R) ? 2'd1 : 2'd0;
                e.wd_sel  = (kind == K_LW) ? 2'd1 : 2'd0;
                e.alu_op = aop; e.alu_b_sel = bs;
                cyc(1'b1, rb(), rb(), ins, e, "wb");
            end
        end
    endtask

    initial begin
        exp_t z, e;
        z = '0;
        reset = 1'b0; mem_ready = 1'b1; equal = 1'b0; instr = 32'h0;

        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, rb(), 32'h00851021, z, "reset_hold");

        run_instr(32'h00851021, 0, 0, 2);   // addu, released straight into FETCH
        run_instr(32'h8C820004, 0, 3, 2);   // lw, 3-cycle data stall
        run_instr(32'hAC820008, 2, 1, 2);   // sw
        run_instr(32'h10850003, 0, 0, 1);   // beq taken
        run_instr(32'h10850003, 1, 0, 0);   // beq not taken
        run_instr(32'h0C000010, 0, 0, 2);   // jal
        run_instr(32'h03E00008, 0, 0, 2);   // jr
        run_instr(32'h00000000, 0, 0, 2);   // nop
        run_instr(32'h3C011234, 0, 0, 2);   // lui
        run_instr(32'h34215678, 0, 0, 2);   // ori

        for (int n = 0; n < 40; n++)
            run_instr(rand_instr(), $urandom_range(0, 3), $urandom_range(0, 3), 2);

        // Reset while a data request is stalled: request dropped at once.
        e = '0; e.mem_req = 1'b1; e.ir_we = 1'b1; e.pc_we = 1'b1; e.dbg = ST_FETCH;
        cyc(1'b1, 1'b1, 1'b0, 32'h8C820004, e, "abort_fetch");
        e = '0; e.dbg = ST_DECODE;
        cyc(1'b1, 1'b0, 1'b0, 32'h8C820004, e, "abort_decode");
        e = '0; e.dbg = ST_EXEC; e.alu_b_sel = 2'd2;
        cyc(1'b1, 1'b0, 1'b0, 32'h8C820004, e, "abort_exec");
        e = '0; e.dbg = ST_MEM; e.alu_b_sel = 2'd2; e.mem_req = 1'b1; e.mem_is_data = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 32'h8C820004, e, "abort_mem_wait");
        cyc(1'b0, 1'b1, 1'b0, 32'h8C820004, z, "reset_mid_mem");
        run_instr(32'h00851021, 1, 0, 2);

        // Illegal opcode: sticky flag, absorbing HALT, cleared only by reset.
        run_instr(32'hFC000000, 0, 0, 2);
        for (int i = 0; i < 20; i++) begin
            e = '0; e.illegal = 1'b1; e.dbg = ST_HALT;
            cyc(1'b1, rb(), rb(), 32'hFC000000, e, "halt");
        end
        cyc(1'b0, 1'b1, 1'b0, 32'hFC000000, z, "reset_in_halt");
        run_instr(32'h00851021, 0, 0, 2);
        run_instr(32'h8C820004, 1, 2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
